// File: rtl/difftest_batch_packer.sv
`default_nettype none
// ============================================================================
// Module      : difftest_batch_packer
// Description : Collects fixed-width difftest records from NUM_CH parallel
//               channels, packs them densely into one OUT_W-bit batch word
//               and hands the batch to a consumer over valid/ready. A batch
//               closes when full, on flush, or after a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module difftest_batch_packer #(
    parameter int ITEM_W  = 64,
    parameter int SLOTS   = 250,
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = $clog2(SLOTS + 1),
    parameter int OUT_W   = SLOTS * ITEM_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*ITEM_W-1:0] in_data,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [CNT_W-1:0]         out_count,
    output logic [1:0]               out_reason
);

    // One extra bit so count + NUM_CH never wraps in the comparisons.
    localparam int c_SUM_W = CNT_W + 1;
    // Timer must hold TIMEOUT itself (one step past the last compare value).
    localparam int c_TMR_W = $clog2(TIMEOUT + 2);

    localparam logic [c_SUM_W-1:0] c_NUM_CH   = c_SUM_W'(NUM_CH);
    localparam logic [c_SUM_W-1:0] c_SLOTS    = c_SUM_W'(SLOTS);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = (TIMEOUT > 0) ? c_TMR_W'(TIMEOUT - 1) : '0;

    localparam logic [1:0] c_RSN_NONE    = 2'd0;
    localparam logic [1:0] c_RSN_FULL    = 2'd1;
    localparam logic [1:0] c_RSN_FLUSH   = 2'd2;
    localparam logic [1:0] c_RSN_TIMEOUT = 2'd3;

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ITEM_W-1:0]   r_buf [SLOTS];
    logic [CNT_W-1:0]    r_count;
    logic [c_TMR_W-1:0]  r_timer;
    logic [CNT_W-1:0]    r_out_count;
    logic [1:0]          r_out_reason;

    logic [NUM_CH-1:0]   w_accept;
    logic [CNT_W-1:0]    w_slot [NUM_CH];
    logic [CNT_W-1:0]    w_run;
    logic [CNT_W-1:0]    w_count_next;
    logic [c_TMR_W-1:0]  w_timer_next;
    logic                w_nonempty;
    logic                w_full;
    logic                w_timeout_hit;
    logic                w_close;
    logic                w_release;
    logic [1:0]          w_reason;

    // Room for a full set of channels is required, so all channels are
    // accepted together regardless of which ones are valid.
    assign in_ready = (r_state == S_FILL) && (({1'b0, r_count} + c_NUM_CH) <= c_SLOTS);

    // enable low masks every channel without touching the handshake.
    assign w_accept = in_valid & {NUM_CH{in_ready & enable}};

    // Compress idle channels out: each accepted record takes the next free slot.
    always_comb begin
        w_run = r_count;
        for (int c = 0; c < NUM_CH; c++) begin
            w_slot[c] = w_run;
            if (w_accept[c]) begin
                w_run = w_run + CNT_W'(1);
            end
        end
        w_count_next = w_run;
    end

    assign w_nonempty    = (w_count_next != '0);
    assign w_full        = (({1'b0, w_count_next} + c_NUM_CH) > c_SLOTS);
    assign w_timeout_hit = (TIMEOUT > 0) && (r_timer == c_TMR_LAST);

    // Next-state and close decision; close sources are prioritised FULL,
    // FLUSH, TIMEOUT and an empty batch never closes.
    always_comb begin
        w_state_next = r_state;
        w_close      = 1'b0;
        w_release    = 1'b0;
        w_reason     = c_RSN_NONE;
        case (r_state)
            S_FILL: begin
                if (w_nonempty) begin
                    if (w_full) begin
                        w_close  = 1'b1;
                        w_reason = c_RSN_FULL;
                    end else if (flush) begin
                        w_close  = 1'b1;
                        w_reason = c_RSN_FLUSH;
                    end else if (w_timeout_hit) begin
                        w_close  = 1'b1;
                        w_reason = c_RSN_TIMEOUT;
                    end
                end
                if (w_close) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_release    = 1'b1;
                    w_state_next = S_FILL;
                end
            end
            default: begin
                w_state_next = S_FILL;
            end
        endcase
    end

    // Age of the open batch: starts counting the cycle after the first record
    // lands, and is frozen while the batch is presented.
    always_comb begin
        w_timer_next = r_timer;
        if (r_state == S_FILL) begin
            if (!w_nonempty) begin
                w_timer_next = '0;
            end else if (r_count != '0) begin
                w_timer_next = r_timer + c_TMR_W'(1);
            end
        end else if (w_release) begin
            w_timer_next = '0;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Batch timer register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_timer <= '0;
        end else begin
            r_timer <= w_timer_next;
        end
    end

    // Record buffer, fill count and closing metadata; the buffer is wiped on
    // release so unused slots of the next batch read as zero.
    always_ff @(posedge clock) begin
        if (reset || w_release) begin
            r_count      <= '0;
            r_out_count  <= '0;
            r_out_reason <= c_RSN_NONE;
            for (int k = 0; k < SLOTS; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            if (r_state == S_FILL) begin
                r_count <= w_count_next;
            end
            if (w_close) begin
                r_out_count  <= w_count_next;
                r_out_reason <= w_reason;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_accept[c]) begin
                    r_buf[w_slot[c]] <= in_data[c*ITEM_W +: ITEM_W];
                end
            end
        end
    end

    assign out_valid  = (r_state == S_HOLD);
    assign out_count  = r_out_count;
    assign out_reason = r_out_reason;

    // No writes occur in HOLD, so the buffer itself is the stable batch word.
    generate
        for (genvar k = 0; k < SLOTS; k++) begin : g_slot
            assign out_data[k*ITEM_W +: ITEM_W] = r_buf[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_difftest_batch_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_difftest_batch_packer
// Description : Self-checking bench for difftest_batch_packer. Accepted
//               records are pushed to a scoreboard queue as they are driven
//               and popped into an expected batch word when a batch closes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_difftest_batch_packer;

    localparam int ITEM_W  = 64;
    localparam int SLOTS   = 250;
    localparam int NUM_CH  = 4;
    localparam int TIMEOUT = 1024;
    localparam int CNT_W   = $clog2(SLOTS + 1);
    localparam int OUT_W   = SLOTS * ITEM_W;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic                     enable = 1'b1;
    logic                     flush = 1'b0;
    logic                     out_ready = 1'b0;
    logic [NUM_CH-1:0]        in_valid = '0;
    logic [NUM_CH*ITEM_W-1:0] in_data = '0;
    logic                     in_ready;
    logic                     out_valid;
    logic [OUT_W-1:0]         out_data;
    logic [CNT_W-1:0]         out_count;
    logic [1:0]               out_reason;

    // Second instance with the timeout disabled.
    logic                     z_enable = 1'b0;
    logic                     z_flush = 1'b0;
    logic                     z_out_ready = 1'b1;
    logic [NUM_CH-1:0]        z_in_valid = '0;
    logic [NUM_CH*ITEM_W-1:0] z_in_data = {NUM_CH{64'h0123_4567_89ab_cdef}};
    logic                     z_in_ready;
    logic                     z_out_valid;
    logic [OUT_W-1:0]         z_out_data;
    logic [CNT_W-1:0]         z_out_count;
    logic [1:0]               z_out_reason;

    int n_cmp = 0;
    int n_err = 0;
    logic [ITEM_W-1:0] sb_q[$];
    logic [OUT_W-1:0]  exp_data;
    int                exp_cnt;
    int                d;

    difftest_batch_packer #(
        .ITEM_W(ITEM_W), .SLOTS(SLOTS), .NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_reason(out_reason)
    );

    difftest_batch_packer #(
        .ITEM_W(ITEM_W), .SLOTS(SLOTS), .NUM_CH(NUM_CH), .TIMEOUT(0)
    ) dut_nto (
        .clock(clock), .reset(reset), .enable(z_enable), .in_valid(z_in_valid),
        .in_data(z_in_data), .in_ready(z_in_ready), .flush(z_flush),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
        .out_count(z_out_count), .out_reason(z_out_reason)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end want end");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive random records on the channels set in v; push them if they will be accepted.
    task automatic drive(input logic [NUM_CH-1:0] v, input bit push);
        logic [ITEM_W-1:0] w;
        in_valid = v;
        for (int c = 0; c < NUM_CH; c++) begin
            w = {$urandom, $urandom};
            in_data[c*ITEM_W +: ITEM_W] = w;
            if (push && v[c]) sb_q.push_back(w);
        end
    endtask

    // Pop everything queued into the expected batch word.
    task automatic build_expected();
        exp_data = '0;
        exp_cnt  = sb_q.size();
        for (int k = 0; k < exp_cnt; k++) begin
            exp_data[k*ITEM_W +: ITEM_W] = sb_q.pop_front();
        end
    endtask

    function automatic int first_diff(input logic [OUT_W-1:0] a, input logic [OUT_W-1:0] b);
        for (int k = 0; k < SLOTS; k++) begin
            if (a[k*ITEM_W +: ITEM_W] !== b[k*ITEM_W +: ITEM_W]) return k;
        end
        return 0;
    endfunction

    function automatic logic [ITEM_W-1:0] slot_of(input logic [OUT_W-1:0] v, input int k);
        return v[k*ITEM_W +: ITEM_W];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", out_count); end
        n_cmp++; if (out_reason !== 2'd0) begin n_err++; $display("FAIL reset_reason: got %0d want 0", out_reason); end
        exp_data = '0;
        n_cmp++; if (out_data !== exp_data) begin
            n_err++; d = first_diff(out_data, exp_data);
            $display("FAIL reset_data: slot %0d got %h want %h", d, slot_of(out_data, d), slot_of(exp_data, d));
        end
        reset = 1'b0;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < 62; i++) begin
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_in_ready cyc %0d: got %b want 1", i, in_ready); end
            drive(4'hF, 1'b1);
            tick();
        end
        drive('0, 1'b0);
        build_expected();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready_drop: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_count !== CNT_W'(248)) begin n_err++; $display("FAIL full_count: got %0d want 248", out_count); end
        n_cmp++; if (out_reason !== 2'd1) begin n_err++; $display("FAIL full_reason: got %0d want 1", out_reason); end
        n_cmp++; if (out_data !== exp_data) begin
            n_err++; d = first_diff(out_data, exp_data);
            $display("FAIL full_data: slot %0d got %h want %h", d, slot_of(out_data, d), slot_of(exp_data, d));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_release_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_flush_sparse();
        drive(4'b1010, 1'b1);
        tick();
        drive('0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        build_expected();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sparse_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_count !== CNT_W'(2)) begin n_err++; $display("FAIL sparse_count: got %0d want 2", out_count); end
        n_cmp++; if (out_reason !== 2'd2) begin n_err++; $display("FAIL sparse_reason: got %0d want 2", out_reason); end
        n_cmp++; if (out_data !== exp_data) begin
            n_err++; d = first_diff(out_data, exp_data);
            $display("FAIL sparse_data: slot %0d got %h want %h", d, slot_of(out_data, d), slot_of(exp_data, d));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sparse_release: got %b want 0", out_valid); end
    endtask

    task automatic test_timeout();
        out_ready = 1'b1;
        drive(4'b0001, 1'b1);
        z_enable = 1'b1;
        z_in_valid = 4'b0001;
        tick();
        drive('0, 1'b0);
        z_in_valid = '0;
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL timeout_early: edge %0d got %b want 0", k, out_valid); end
        end
        tick();
        build_expected();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL timeout_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_count !== CNT_W'(1)) begin n_err++; $display("FAIL timeout_count: got %0d want 1", out_count); end
        n_cmp++; if (out_reason !== 2'd3) begin n_err++; $display("FAIL timeout_reason: got %0d want 3", out_reason); end
        n_cmp++; if (out_data !== exp_data) begin
            n_err++; d = first_diff(out_data, exp_data);
            $display("FAIL timeout_data: slot %0d got %h want %h", d, slot_of(out_data, d), slot_of(exp_data, d));
        end
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL timeout_release: got %b want 0", out_valid); end
        for (int k = 0; k < 200; k++) begin
            tick();
        end
        n_cmp++; if (z_out_valid !== 1'b0) begin n_err++; $display("FAIL timeout_disabled: got %b want 0", z_out_valid); end
        n_cmp++; if (z_in_ready !== 1'b1) begin n_err++; $display("FAIL timeout_disabled_ready: got %b want 1", z_in_ready); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(4'b0111, 1'b1);
        tick();
        drive('0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        build_expected();
        for (int i = 0; i < 20; i++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid cyc %0d: got %b want 1", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc %0d: got %b want 0", i, in_ready); end
            n_cmp++; if (out_count !== CNT_W'(3)) begin n_err++; $display("FAIL bp_count cyc %0d: got %0d want 3", i, out_count); end
            n_cmp++; if (out_reason !== 2'd2) begin n_err++; $display("FAIL bp_reason cyc %0d: got %0d want 2", i, out_reason); end
            n_cmp++; if (out_data !== exp_data) begin
                n_err++; d = first_diff(out_data, exp_data);
                $display("FAIL bp_data cyc %0d: slot %0d got %h want %h", i, d, slot_of(out_data, d), slot_of(exp_data, d));
            end
            drive(4'hF, 1'b0);
            flush = (i == 7);
            tick();
        end
        drive('0, 1'b0);
        flush = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_flush_queued cyc %0d: got %b want 0", i, out_valid); end
            tick();
        end
        drive(4'b0001, 1'b1);
        tick();
        drive('0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        build_expected();
        n_cmp++; if (out_count !== CNT_W'(exp_cnt)) begin n_err++; $display("FAIL bp_after_count: got %0d want %0d", out_count, exp_cnt); end
        n_cmp++; if (out_data !== exp_data) begin
            n_err++; d = first_diff(out_data, exp_data);
            $display("FAIL bp_after_data: slot %0d got %h want %h", d, slot_of(out_data, d), slot_of(exp_data, d));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush_empty();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL empty_flush cyc %0d: got %b want 0", i, out_valid); end
            tick();
        end
        drive(4'b1101, 1'b1);
        flush = 1'b1;
        tick();
        drive('0, 1'b0);
        flush = 1'b0;
        build_expected();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL same_cycle_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_count !== CNT_W'(3)) begin n_err++; $display("FAIL same_cycle_count: got %0d want 3", out_count); end
        n_cmp++; if (out_reason !== 2'd2) begin n_err++; $display("FAIL same_cycle_reason: got %0d want 2", out_reason); end
        n_cmp++; if (out_data !== exp_data) begin
            n_err++; d = first_diff(out_data, exp_data);
            $display("FAIL same_cycle_data: slot %0d got %h want %h", d, slot_of(out_data, d), slot_of(exp_data, d));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_enable_low();
        enable = 1'b0;
        drive(4'hF, 1'b0);
        tick();
        drive('0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL en_low_valid: got %b want 0", out_valid); end
        enable = 1'b1;
        drive(4'b0011, 1'b1);
        tick();
        enable = 1'b0;
        drive(4'hF, 1'b0);
        flush = 1'b1;
        tick();
        drive('0, 1'b0);
        flush = 1'b0;
        enable = 1'b1;
        build_expected();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL en_low_close: got %b want 1", out_valid); end
        n_cmp++; if (out_count !== CNT_W'(2)) begin n_err++; $display("FAIL en_low_count: got %0d want 2", out_count); end
        n_cmp++; if (out_data !== exp_data) begin
            n_err++; d = first_diff(out_data, exp_data);
            $display("FAIL en_low_data: slot %0d got %h want %h", d, slot_of(out_data, d), slot_of(exp_data, d));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_hold();
        drive(4'hF, 1'b1);
        tick();
        drive(4'hF, 1'b1);
        tick();
        drive(4'b0011, 1'b1);
        tick();
        drive('0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (out_count !== CNT_W'(10)) begin n_err++; $display("FAIL rh_count: got %0d want 10", out_count); end
        sb_q.delete();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rh_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rh_in_ready: got %b want 1", in_ready); end
        drive(4'b0100, 1'b1);
        tick();
        drive('0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        build_expected();
        n_cmp++; if (out_count !== CNT_W'(1)) begin n_err++; $display("FAIL rh_new_count: got %0d want 1", out_count); end
        n_cmp++; if (out_reason !== 2'd2) begin n_err++; $display("FAIL rh_new_reason: got %0d want 2", out_reason); end
        n_cmp++; if (out_data !== exp_data) begin
            n_err++; d = first_diff(out_data, exp_data);
            $display("FAIL rh_new_data: slot %0d got %h want %h", d, slot_of(out_data, d), slot_of(exp_data, d));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full();
        test_flush_sparse();
        test_timeout();
        test_backpressure();
        test_flush_empty();
        test_enable_low();
        test_reset_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
